// File: rtl/button_strobe_conditioner_pkg.sv
// Shared constants and helpers for the two-channel button conditioner.
package btn_cond_pkg;

  localparam int unsigned DEF_TICK_DIV     = 32'd1_000_000;
  localparam int unsigned DEF_STABLE_TICKS = 32'd3;
  localparam int unsigned DEF_REPEAT_EN    = 32'd1;
  localparam int unsigned DEF_REPEAT_DELAY = 32'd50;
  localparam int unsigned DEF_REPEAT_RATE  = 32'd10;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  localparam int unsigned TICK_W = cnt_w(DEF_TICK_DIV);
  localparam int unsigned HOLD_W = cnt_w(DEF_REPEAT_DELAY + 32'd1);

endpackage

// File: rtl/button_strobe_conditioner_if.sv
// Button/strobe bundle between the conditioner and its user.
interface button_strobe_conditioner_if;
  logic ena;
  logic btn_inc_raw;
  logic btn_dec_raw;
  logic duty_inc;
  logic duty_dec;
  logic inc_level;
  logic dec_level;
  logic tick;

  modport master (
    output ena, btn_inc_raw, btn_dec_raw,
    input  duty_inc, duty_dec, inc_level, dec_level, tick
  );

  modport slave (
    input  ena, btn_inc_raw, btn_dec_raw,
    output duty_inc, duty_dec, inc_level, dec_level, tick
  );
endinterface

// File: rtl/button_strobe_conditioner_debounce_channel.sv
// One button channel: synchroniser, tick-sampled debounce, press and auto-repeat strobe.
module debounce_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_EN    = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_raw,
  input  logic i_suppress_rep,
  output logic o_level,
  output logic o_strobe_raw
);

  localparam int unsigned SW = cnt_w(STABLE_TICKS + 32'd1);
  localparam int unsigned HW = cnt_w(REPEAT_DELAY + 32'd1);
  // A rate longer than the delay would need a negative reload; restart from zero instead.
  localparam int unsigned RELOAD = (REPEAT_RATE >= REPEAT_DELAY) ? 32'd0 : (REPEAT_DELAY - REPEAT_RATE);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_strobe;
  logic [SW-1:0] r_stab;
  logic [HW-1:0] r_hold;

  logic          w_level_nxt;
  logic [SW-1:0] w_stab_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_flip;
  logic          w_fire;

  // Next-state for debounce level, stable counter, hold counter and strobe request.
  always_comb begin
    w_level_nxt = r_level;
    w_stab_nxt  = r_stab;
    w_hold_nxt  = r_hold;
    w_flip      = 1'b0;
    w_fire      = 1'b0;
    if (i_tick) begin
      if (r_sync2 != r_level) begin
        if (r_stab == SW'(STABLE_TICKS - 32'd1)) begin
          w_level_nxt = r_sync2;
          w_stab_nxt  = '0;
          w_flip      = 1'b1;
        end else begin
          w_stab_nxt = r_stab + SW'(1);
        end
      end else begin
        w_stab_nxt = '0;
      end

      if (w_flip) begin
        // Press restarts the hold time and strobes; release just clears it.
        w_hold_nxt = '0;
        w_fire     = r_sync2;
      end else if (r_level) begin
        if ((REPEAT_EN != 32'd0) && (r_hold == HW'(REPEAT_DELAY - 32'd1))) begin
          w_hold_nxt = HW'(RELOAD);
          w_fire     = ~i_suppress_rep;
        end else if (r_hold != HW'(REPEAT_DELAY)) begin
          w_hold_nxt = r_hold + HW'(1);
        end else begin
          w_hold_nxt = r_hold;
        end
      end else begin
        w_hold_nxt = '0;
      end
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Synchroniser and channel state registers; a strobe never follows a strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_level  <= 1'b0;
      r_strobe <= 1'b0;
      r_stab   <= '0;
      r_hold   <= '0;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_level  <= w_level_nxt;
      r_stab   <= w_stab_nxt;
      r_hold   <= w_hold_nxt;
      r_strobe <= w_fire & ~r_strobe;
    end
  end

  assign o_level      = r_level;
  assign o_strobe_raw = r_strobe;

endmodule

// File: rtl/button_strobe_conditioner.sv
// Two-channel button conditioner: sample-tick prescaler, two debounce channels,
// mutual-exclusion arbitration and enable gating of the duty-step strobes.
module button_strobe_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_EN    = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  button_strobe_conditioner_if.slave   io_btn
);

  localparam int unsigned TW = cnt_w(TICK_DIV);

  logic [TW-1:0] r_tick_cnt;
  logic          r_tick;
  logic          w_level_inc;
  logic          w_level_dec;
  logic          w_strobe_inc;
  logic          w_strobe_dec;
  logic          w_both_held;

  // Prescaler: wraps every TICK_DIV clocks and emits a registered one-clock tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      if (r_tick_cnt == TW'(TICK_DIV - 32'd1)) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
      end
      r_tick <= (r_tick_cnt == TW'(TICK_DIV - 32'd1));
    end
  end

  // Holding both buttons is ambiguous, so neither channel auto-repeats.
  assign w_both_held = w_level_inc & w_level_dec;

  debounce_channel #(
    .STABLE_TICKS (STABLE_TICKS),
    .REPEAT_EN    (REPEAT_EN),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_ch_inc (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_tick         (r_tick),
    .i_raw          (io_btn.btn_inc_raw),
    .i_suppress_rep (w_both_held),
    .o_level        (w_level_inc),
    .o_strobe_raw   (w_strobe_inc)
  );

  debounce_channel #(
    .STABLE_TICKS (STABLE_TICKS),
    .REPEAT_EN    (REPEAT_EN),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_ch_dec (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_tick         (r_tick),
    .i_raw          (io_btn.btn_dec_raw),
    .i_suppress_rep (w_both_held),
    .o_level        (w_level_dec),
    .o_strobe_raw   (w_strobe_dec)
  );

  // Simultaneous strobes cancel; ena only gates the strobes, never the filtering.
  assign io_btn.duty_inc  = io_btn.ena & w_strobe_inc & ~w_strobe_dec;
  assign io_btn.duty_dec  = io_btn.ena & w_strobe_dec & ~w_strobe_inc;
  assign io_btn.inc_level = w_level_inc;
  assign io_btn.dec_level = w_level_dec;
  assign io_btn.tick      = r_tick;

endmodule

// File: tb/tb_button_strobe_conditioner.sv
// Self-checking bench: directed scenarios plus random button activity, compared
// every clock against a tick-level behavioural model of the conditioner.
module tb_button_strobe_conditioner;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RE = 1;
  localparam int RD = 8;
  localparam int RR = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  button_strobe_conditioner_if bif ();

  button_strobe_conditioner #(
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .REPEAT_EN    (RE),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_btn (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: channel 0 = inc, channel 1 = dec.
  int m_edges;
  bit m_tick;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_lvl [2];
  bit m_stb [2];
  int m_diff [2];
  int m_held [2];
  int obs_cnt [2];
  int exp_cnt [2];
  int win_lvl_seen [2];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT saw at that edge.
  task automatic model_edge(input bit r, input bit raw_inc, input bit raw_dec);
    bit both;
    bit nstb [2];
    bit raws [2];
    bit flipped;
    if (r) begin
      m_edges = 0;
      m_tick  = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0; m_stb[c] = 1'b0;
        m_diff[c] = 0; m_held[c] = 0;
      end
    end else begin
      both    = m_lvl[0] & m_lvl[1];
      raws[0] = raw_inc;
      raws[1] = raw_dec;
      for (int c = 0; c < 2; c++) begin
        nstb[c] = 1'b0;
        if (m_tick) begin
          flipped = 1'b0;
          if (m_s2[c] != m_lvl[c]) begin
            m_diff[c]++;
            if (m_diff[c] == ST) begin
              m_lvl[c]  = m_s2[c];
              m_diff[c] = 0;
              m_held[c] = 0;
              flipped   = 1'b1;
              nstb[c]   = m_lvl[c];
            end
          end else begin
            m_diff[c] = 0;
          end
          if (!flipped && m_lvl[c]) begin
            m_held[c]++;
            if (RE != 0 && m_held[c] >= RD && ((m_held[c] - RD) % RR) == 0 && !both)
              nstb[c] = 1'b1;
          end
        end
        nstb[c] = nstb[c] & ~m_stb[c];
      end
      for (int c = 0; c < 2; c++) begin
        m_stb[c] = nstb[c];
        m_s2[c]  = m_s1[c];
        m_s1[c]  = raws[c];
      end
      m_edges++;
      m_tick = ((m_edges % TD) == 0);
    end
  endtask

  // One clock: update model at the edge, compare all outputs 1 time unit later.
  task automatic step();
    bit e_inc;
    bit e_dec;
    @(posedge clk);
    model_edge(rst, bif.btn_inc_raw, bif.btn_dec_raw);
    #1;
    e_inc = bif.ena & m_stb[0] & ~m_stb[1];
    e_dec = bif.ena & m_stb[1] & ~m_stb[0];
    check_eq("tick", bif.tick, m_tick);
    check_eq("inc_level", bif.inc_level, m_lvl[0]);
    check_eq("dec_level", bif.dec_level, m_lvl[1]);
    check_eq("duty_inc", bif.duty_inc, e_inc);
    check_eq("duty_dec", bif.duty_dec, e_dec);
    obs_cnt[0] += bif.duty_inc;
    obs_cnt[1] += bif.duty_dec;
    exp_cnt[0] += e_inc;
    exp_cnt[1] += e_dec;
    if (bif.inc_level) win_lvl_seen[0]++;
    if (bif.dec_level) win_lvl_seen[1]++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_win();
    for (int c = 0; c < 2; c++) begin
      obs_cnt[c] = 0; exp_cnt[c] = 0; win_lvl_seen[c] = 0;
    end
  endtask

  initial begin
    int k;
    checks   = 0;
    failures = 0;
    clear_win();
    rst = 1'b1;
    bif.ena = 1'b1;
    bif.btn_inc_raw = 1'b1;
    bif.btn_dec_raw = 1'b1;

    // 1. Reset with buttons high, then first tick latency.
    run(3);
    check_eq("rst_outputs", {bif.duty_inc, bif.duty_dec, bif.inc_level, bif.dec_level, bif.tick}, 0);
    rst = 1'b0;
    bif.btn_inc_raw = 1'b0;
    bif.btn_dec_raw = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!bif.tick && k < 20);
    check_eq("first_tick_lat", k, TD);
    run(10 * TD);

    // 2. Clean inc press: exactly one strobe before the first repeat could occur.
    clear_win();
    bif.btn_inc_raw = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!bif.inc_level && k < 40);
    check_eq("t2_rise_in_budget", (k >= 2 * TD + 2 && k <= 3 * TD + 4) ? 1 : 0, 1);
    run(10 * TD - k);
    check_eq("t2_inc_strobes", obs_cnt[0], 1);
    check_eq("t2_dec_strobes", obs_cnt[1], 0);
    run(10 * TD);
    bif.btn_inc_raw = 1'b0;
    run(10 * TD);
    check_eq("t2_inc_released", bif.inc_level, 0);

    // 3. Bounce shorter than the stable window.
    clear_win();
    bif.btn_inc_raw = 1'b1; run(TD);
    bif.btn_inc_raw = 1'b0; run(TD);
    bif.btn_inc_raw = 1'b1; run(TD);
    bif.btn_inc_raw = 1'b0; run(10 * TD);
    check_eq("t3_no_level", win_lvl_seen[0], 0);
    check_eq("t3_no_strobe", obs_cnt[0], 0);

    // 4. dec held 30 ticks with auto-repeat.
    clear_win();
    bif.btn_dec_raw = 1'b1; run(30 * TD);
    bif.btn_dec_raw = 1'b0; run(10 * TD);
    check_eq("t4_dec_strobes", obs_cnt[1], exp_cnt[1]);
    check_eq("t4_repeated", (obs_cnt[1] >= 8) ? 1 : 0, 1);

    // 5. Both buttons on the same clock.
    clear_win();
    bif.btn_inc_raw = 1'b1;
    bif.btn_dec_raw = 1'b1;
    run(20 * TD);
    check_eq("t5_inc_strobes", obs_cnt[0], 0);
    check_eq("t5_dec_strobes", obs_cnt[1], 0);
    check_eq("t5_levels", {bif.inc_level, bif.dec_level}, 3);
    bif.btn_inc_raw = 1'b0;
    bif.btn_dec_raw = 1'b0;
    run(10 * TD);

    // 6. ena low during press, then reset mid-hold and release.
    clear_win();
    bif.ena = 1'b0;
    bif.btn_inc_raw = 1'b1;
    run(15 * TD);
    check_eq("t6_gated", obs_cnt[0], 0);
    check_eq("t6_level", bif.inc_level, 1);
    bif.ena = 1'b1;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    bif.btn_inc_raw = 1'b0;
    clear_win();
    run(10 * TD);
    check_eq("t6_after_rst", win_lvl_seen[0] + obs_cnt[0], 0);
    bif.btn_inc_raw = 1'b1;
    run(2 * TD);
    check_eq("t6_fresh_window", bif.inc_level, 0);
    run(20 * TD);
    check_eq("t6_fresh_press", obs_cnt[0], exp_cnt[0]);
    bif.btn_inc_raw = 1'b0;
    run(10 * TD);

    // 7. Random activity, occasional resets and enable changes.
    clear_win();
    for (int s = 0; s < 120; s++) begin
      bif.btn_inc_raw = 1'($urandom_range(0, 1));
      bif.btn_dec_raw = 1'($urandom_range(0, 3) == 0);
      bif.ena         = 1'($urandom_range(0, 7) != 0);
      rst             = 1'($urandom_range(0, 19) == 0);
      step();
      rst = 1'b0;
      run($urandom_range(1, 14 * TD));
    end
    check_eq("rand_inc_count", obs_cnt[0], exp_cnt[0]);
    check_eq("rand_dec_count", obs_cnt[1], exp_cnt[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
